// File: rtl/decode_pkg.sv
// Shared encodings for the D-stage decoder and block-transfer sequencer.
package decode_pkg;

    // Instruction classes (Op field)
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // ALUControl codes (zero-extended to ALUW where used)
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_ORR = 5'b00011;
    localparam logic [4:0] ALU_EOR = 5'b00110;
    localparam logic [4:0] ALU_RSB = 5'b01000;
    localparam logic [4:0] ALU_BIC = 5'b10010;

    // Immediate select
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;
    localparam logic [1:0] IMM_SEQ = 2'b11;   // datapath uses {SeqOff,2'b00}

    // Register-read select
    localparam logic [1:0] REG_DP  = 2'b00;
    localparam logic [1:0] REG_BR  = 2'b01;
    localparam logic [1:0] REG_STR = 2'b10;

    typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} seq_state_t;

    // Single-bit E-stage enables plus flag writes
    typedef struct packed {
        logic       RegW;
        logic       MemW;
        logic       MemtoReg;
        logic       ALUSrc;
        logic       Branch;
        logic       NoWrite;
        logic       IgRn;
        logic [1:0] FlagW;
    } ctl_t;

endpackage

// File: rtl/decode_seq_if.sv
// D-stage instruction inputs and E-stage control outputs of decode_seq.
interface decode_seq_if #(
    parameter int REGS = 16,
    parameter int ALUW = 5
);
    localparam int IW = $clog2(REGS);

    logic            ValidD;
    logic [1:0]      Op;
    logic [5:0]      Funct;
    logic [3:0]      Rd;
    logic [REGS-1:0] RegList;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;

    logic            BusyD;
    logic [1:0]      ImmSrcD;
    logic [1:0]      RegSrcD;
    logic [IW-1:0]   SeqRegD;

    logic            RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, PCSE, NoWriteE, IgRnE;
    logic [1:0]      FlagWE;
    logic [ALUW-1:0] ALUControlE;
    logic [IW-1:0]   SeqRegE;
    logic [IW-1:0]   SeqOffE;

    modport master (
        output ValidD, Op, Funct, Rd, RegList, StallD, FlushD, FlushE,
        input  BusyD, ImmSrcD, RegSrcD, SeqRegD,
        input  RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, PCSE, NoWriteE, IgRnE,
        input  FlagWE, ALUControlE, SeqRegE, SeqOffE
    );

    modport slave (
        input  ValidD, Op, Funct, Rd, RegList, StallD, FlushD, FlushE,
        output BusyD, ImmSrcD, RegSrcD, SeqRegD,
        output RegWE, MemWE, MemtoRegE, ALUSrcE, BranchE, PCSE, NoWriteE, IgRnE,
        output FlagWE, ALUControlE, SeqRegE, SeqOffE
    );
endinterface

// File: rtl/decode_alu_table.sv
// Data-processing Funct -> ALUControl / NoWrite / IgRn / FlagW map.
module decode_alu_table
    import decode_pkg::*;
#(
    parameter int ALUW = 5
) (
    input  logic [4:0]      i_funct,
    output logic [ALUW-1:0] o_alu,
    output logic            o_nowrite,
    output logic            o_igrn,
    output logic [1:0]      o_flagw,
    output logic            o_def
);
    logic [4:0] w_code;

    // Opcode lookup; undefined codes clear o_def so the caller drops every enable
    always_comb begin
        w_code    = ALU_ADD;
        o_nowrite = 1'b0;
        o_igrn    = 1'b0;
        o_def     = 1'b1;
        case (i_funct[4:1])
            4'b0000: w_code = ALU_AND;
            4'b0001: w_code = ALU_EOR;
            4'b0010: w_code = ALU_SUB;
            4'b0011: w_code = ALU_RSB;
            4'b0100: w_code = ALU_ADD;
            4'b1100: w_code = ALU_ORR;
            4'b1110: w_code = ALU_BIC;
            4'b1101: begin w_code = ALU_ADD; o_igrn = 1'b1; end
            4'b1000: begin w_code = ALU_AND; o_nowrite = 1'b1; end
            4'b1001: begin w_code = ALU_EOR; o_nowrite = 1'b1; end
            4'b1010: begin w_code = ALU_SUB; o_nowrite = 1'b1; end
            4'b1011: begin w_code = ALU_ADD; o_nowrite = 1'b1; end
            default: o_def = 1'b0;
        endcase
    end

    // Logical ops (ALUControl[1]=1) leave C/V alone
    assign o_alu   = o_def ? ALUW'(w_code) : '0;
    assign o_flagw = o_def ? {i_funct[0], i_funct[0] & ~w_code[1]} : 2'b00;
endmodule

// File: rtl/decode_seq.sv
// D-stage decoder with LDM/STM beat sequencer and D->E control register.
module decode_seq
    import decode_pkg::*;
#(
    parameter int REGS = 16,
    parameter int ALUW = 5
) (
    input logic          clk,
    input logic          reset,
    decode_seq_if.slave  bus
);
    localparam int IW = $clog2(REGS);

    seq_state_t      r_state;
    logic [REGS-1:0] r_mask;
    logic [IW-1:0]   r_off;
    logic            r_ldm;

    logic            w_xfer, w_blkop, w_blk, w_beat, w_ldm, w_bubble, w_pcs;
    logic [REGS-1:0] w_cur, w_rest;
    logic [IW-1:0]   w_seqreg, w_seqoff;
    logic [3:0]      w_dst;
    logic [1:0]      w_imm, w_rsrc;
    logic [ALUW-1:0] w_alu, w_talu;
    logic            w_tnowrite, w_tigrn, w_tdef;
    logic [1:0]      w_tflagw;
    ctl_t            w_ctl;

    decode_alu_table #(.ALUW(ALUW)) u_alu_table (
        .i_funct   (bus.Funct[4:0]),
        .o_alu     (w_talu),
        .o_nowrite (w_tnowrite),
        .o_igrn    (w_tigrn),
        .o_flagw   (w_tflagw),
        .o_def     (w_tdef)
    );

    // Remaining mask: live RegList when a block op arrives in IDLE, latched mask in XFER
    assign w_xfer  = (r_state == S_XFER);
    assign w_blkop = (bus.Op == OP_BR) & ~bus.Funct[5];
    assign w_blk   = w_xfer | w_blkop;
    assign w_cur   = w_xfer ? r_mask : ((bus.ValidD & w_blkop) ? bus.RegList : '0);
    assign w_rest  = w_cur & (w_cur - 1'b1);
    assign w_beat  = |w_cur;
    assign w_ldm   = w_xfer ? r_ldm : bus.Funct[0];
    assign w_seqoff = w_xfer ? r_off : '0;

    // Lowest set bit of the remaining mask selects this beat's register
    always_comb begin
        w_seqreg = '0;
        for (int i = REGS - 1; i >= 0; i--)
            if (w_cur[i]) w_seqreg = IW'(i);
    end

    // Main D-stage decode; block ops with an empty mask fall through as a bubble
    always_comb begin
        w_ctl  = '0;
        w_alu  = '0;
        w_imm  = IMM_DP;
        w_rsrc = REG_DP;
        if (w_blk) begin
            if (w_beat) begin
                w_ctl.ALUSrc = 1'b1;
                w_imm        = IMM_SEQ;
                w_alu        = ALUW'(ALU_ADD);
                if (w_ldm) begin
                    w_ctl.RegW     = 1'b1;
                    w_ctl.MemtoReg = 1'b1;
                end else begin
                    w_ctl.MemW = 1'b1;
                    w_rsrc     = REG_STR;
                end
            end
        end else begin
            case (bus.Op)
                OP_DP: begin
                    w_ctl.RegW    = w_tdef;
                    w_ctl.ALUSrc  = bus.Funct[5] & w_tdef;
                    w_ctl.NoWrite = w_tnowrite;
                    w_ctl.IgRn    = w_tigrn;
                    w_ctl.FlagW   = w_tflagw;
                    w_alu         = w_talu;
                end
                OP_MEM: begin
                    w_imm        = IMM_MEM;
                    w_ctl.ALUSrc = 1'b1;
                    w_alu        = ALUW'(ALU_ADD);
                    if (bus.Funct[0]) begin
                        w_ctl.RegW     = 1'b1;
                        w_ctl.MemtoReg = 1'b1;
                    end else begin
                        w_ctl.MemW = 1'b1;
                        w_rsrc     = REG_STR;
                    end
                end
                OP_BR: begin
                    w_imm        = IMM_BR;
                    w_ctl.ALUSrc = 1'b1;
                    w_ctl.Branch = 1'b1;
                    w_rsrc       = REG_BR;
                    w_alu        = ALUW'(ALU_ADD);
                end
                default: ;
            endcase
        end
    end

    assign w_dst    = w_beat ? 4'(w_seqreg) : bus.Rd;
    assign w_pcs    = ((w_dst == 4'd15) & w_ctl.RegW) | w_ctl.Branch;
    assign w_bubble = bus.FlushE | bus.StallD | bus.FlushD | (~w_xfer & ~bus.ValidD);

    assign bus.BusyD   = w_beat & (|w_rest) & ~bus.FlushD;
    assign bus.ImmSrcD = w_imm;
    assign bus.RegSrcD = w_rsrc;
    assign bus.SeqRegD = w_seqreg;

    // Sequencer: reset > FlushD > StallD; each unstalled beat clears its bit
    always_ff @(posedge clk) begin
        if (reset || bus.FlushD) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_off   <= '0;
            r_ldm   <= 1'b0;
        end else if (!bus.StallD) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.ValidD && w_blkop && (|w_rest)) begin
                        r_state <= S_XFER;
                        r_mask  <= w_rest;
                        r_off   <= IW'(1);
                        r_ldm   <= bus.Funct[0];
                    end
                end
                S_XFER: begin
                    r_mask <= w_rest;
                    if (~|w_rest) begin
                        r_state <= S_IDLE;
                        r_off   <= '0;
                    end else begin
                        r_off <= r_off + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // D->E pipeline register; bubbles carry all-zero controls
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            bus.RegWE       <= 1'b0;
            bus.MemWE       <= 1'b0;
            bus.MemtoRegE   <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.PCSE        <= 1'b0;
            bus.NoWriteE    <= 1'b0;
            bus.IgRnE       <= 1'b0;
            bus.FlagWE      <= 2'b00;
            bus.ALUControlE <= '0;
            bus.SeqRegE     <= '0;
            bus.SeqOffE     <= '0;
        end else begin
            bus.RegWE       <= w_ctl.RegW;
            bus.MemWE       <= w_ctl.MemW;
            bus.MemtoRegE   <= w_ctl.MemtoReg;
            bus.ALUSrcE     <= w_ctl.ALUSrc;
            bus.BranchE     <= w_ctl.Branch;
            bus.PCSE        <= w_pcs;
            bus.NoWriteE    <= w_ctl.NoWrite;
            bus.IgRnE       <= w_ctl.IgRn;
            bus.FlagWE      <= w_ctl.FlagW;
            bus.ALUControlE <= w_alu;
            bus.SeqRegE     <= w_beat ? w_seqreg : '0;
            bus.SeqOffE     <= w_beat ? w_seqoff : '0;
        end
    end
endmodule

// File: tb/tb_decode_seq.sv
// Directed checks of decode_seq (REGS=16 and REGS=8 builds driven in lockstep).
module tb_decode_seq;
    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    decode_seq_if #(.REGS(16), .ALUW(5)) bus  ();
    decode_seq_if #(.REGS(8),  .ALUW(5)) bus8 ();

    decode_seq #(.REGS(16), .ALUW(5)) dut  (.clk(clk), .reset(reset), .bus(bus));
    decode_seq #(.REGS(8),  .ALUW(5)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Drive both builds; RegList for the 8-register build is the low byte
    task automatic setd(input logic v, input logic [1:0] op, input logic [5:0] fn,
                        input logic [3:0] rd, input logic [15:0] rl,
                        input logic st, input logic fd, input logic fe);
        bus.ValidD  = v;  bus.Op  = op;  bus.Funct  = fn;  bus.Rd  = rd;  bus.RegList  = rl;
        bus.StallD  = st; bus.FlushD  = fd; bus.FlushE  = fe;
        bus8.ValidD = v;  bus8.Op = op;  bus8.Funct = fn;  bus8.Rd = rd;  bus8.RegList = rl[7:0];
        bus8.StallD = st; bus8.FlushD = fd; bus8.FlushE = fe;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        setd(0, 2'b00, 6'b0, 4'd0, 16'h0, 0, 0, 0);
        tick; tick;
        chk("rst RegWE", bus.RegWE, 0);
        chk("rst ALUControlE", bus.ALUControlE, 0);
        chk("rst SeqRegE", bus.SeqRegE, 0);
        chk("rst BusyD", bus.BusyD, 0);
        reset = 1'b0;

        // CMP with S
        setd(1, 2'b00, 6'b010101, 4'd0, 16'h0, 0, 0, 0);
        chk("cmp ImmSrcD", bus.ImmSrcD, 2'b00);
        tick;
        chk("cmp ALUControlE", bus.ALUControlE, 5'b00001);
        chk("cmp FlagWE", bus.FlagWE, 2'b11);
        chk("cmp NoWriteE", bus.NoWriteE, 1);
        chk("cmp RegWE", bus.RegWE, 1);
        chk("cmp ALUSrcE", bus.ALUSrcE, 0);

        // ANDS: logical op only writes N/Z
        setd(1, 2'b00, 6'b000001, 4'd2, 16'h0, 0, 0, 0);
        tick;
        chk("ands ALUControlE", bus.ALUControlE, 5'b00010);
        chk("ands FlagWE", bus.FlagWE, 2'b10);
        chk("ands NoWriteE", bus.NoWriteE, 0);

        // ADD immediate into PC
        setd(1, 2'b00, 6'b101000, 4'd15, 16'h0, 0, 0, 0);
        tick;
        chk("addpc ALUSrcE", bus.ALUSrcE, 1);
        chk("addpc PCSE", bus.PCSE, 1);
        chk("addpc FlagWE", bus.FlagWE, 2'b00);

        // MOV, BIC
        setd(1, 2'b00, 6'b011010, 4'd3, 16'h0, 0, 0, 0);
        tick;
        chk("mov IgRnE", bus.IgRnE, 1);
        chk("mov ALUControlE", bus.ALUControlE, 5'b00000);
        setd(1, 2'b00, 6'b011100, 4'd3, 16'h0, 0, 0, 0);
        tick;
        chk("bic ALUControlE", bus.ALUControlE, 5'b10010);
        chk("bic IgRnE", bus.IgRnE, 0);

        // Undefined code 0101 with S set
        setd(1, 2'b00, 6'b001011, 4'd3, 16'h0, 0, 0, 0);
        tick;
        chk("undef RegWE", bus.RegWE, 0);
        chk("undef FlagWE", bus.FlagWE, 2'b00);

        // LDR / STR
        setd(1, 2'b01, 6'b011001, 4'd4, 16'h0, 0, 0, 0);
        chk("ldr ImmSrcD", bus.ImmSrcD, 2'b01);
        chk("ldr RegSrcD", bus.RegSrcD, 2'b00);
        tick;
        chk("ldr RegWE", bus.RegWE, 1);
        chk("ldr MemtoRegE", bus.MemtoRegE, 1);
        chk("ldr ALUSrcE", bus.ALUSrcE, 1);
        setd(1, 2'b01, 6'b011000, 4'd4, 16'h0, 0, 0, 0);
        chk("str RegSrcD", bus.RegSrcD, 2'b10);
        tick;
        chk("str MemWE", bus.MemWE, 1);
        chk("str RegWE", bus.RegWE, 0);

        // Branch
        setd(1, 2'b10, 6'b100000, 4'd0, 16'h0, 0, 0, 0);
        chk("b ImmSrcD", bus.ImmSrcD, 2'b10);
        chk("b RegSrcD", bus.RegSrcD, 2'b01);
        tick;
        chk("b BranchE", bus.BranchE, 1);
        chk("b PCSE", bus.PCSE, 1);

        // NOP class, FlushE, invalid
        setd(1, 2'b11, 6'b111111, 4'd15, 16'h0, 0, 0, 0);
        tick;
        chk("nop RegWE", bus.RegWE, 0);
        chk("nop PCSE", bus.PCSE, 0);
        setd(1, 2'b00, 6'b001000, 4'd1, 16'h0, 0, 0, 1);
        tick;
        chk("flushE RegWE", bus.RegWE, 0);
        setd(0, 2'b00, 6'b001000, 4'd1, 16'h0, 0, 0, 0);
        tick;
        chk("invalid RegWE", bus.RegWE, 0);

        // LDM 0x8003: beats r0, r1, r15
        setd(1, 2'b10, 6'b000001, 4'd0, 16'h8003, 0, 0, 0);
        chk("ldm b1 BusyD", bus.BusyD, 1);
        chk("ldm b1 SeqRegD", bus.SeqRegD, 0);
        chk("ldm b1 ImmSrcD", bus.ImmSrcD, 2'b11);
        tick;
        chk("ldm b1 RegWE", bus.RegWE, 1);
        chk("ldm b1 MemtoRegE", bus.MemtoRegE, 1);
        chk("ldm b1 SeqRegE", bus.SeqRegE, 0);
        chk("ldm b1 SeqOffE", bus.SeqOffE, 0);
        chk("ldm b1 PCSE", bus.PCSE, 0);
        chk("ldm b2 BusyD", bus.BusyD, 1);
        chk("ldm b2 SeqRegD", bus.SeqRegD, 1);
        tick;
        chk("ldm b2 SeqRegE", bus.SeqRegE, 1);
        chk("ldm b2 SeqOffE", bus.SeqOffE, 1);
        chk("ldm b2 PCSE", bus.PCSE, 0);
        chk("ldm b3 BusyD", bus.BusyD, 0);
        chk("ldm b3 SeqRegD", bus.SeqRegD, 15);
        tick;
        chk("ldm b3 SeqRegE", bus.SeqRegE, 15);
        chk("ldm b3 SeqOffE", bus.SeqOffE, 2);
        chk("ldm b3 PCSE", bus.PCSE, 1);

        // STM with empty list, then ADD accepted next cycle
        setd(1, 2'b10, 6'b000000, 4'd0, 16'h0000, 0, 0, 0);
        chk("stm0 BusyD", bus.BusyD, 0);
        tick;
        chk("stm0 MemWE", bus.MemWE, 0);
        chk("stm0 RegWE", bus.RegWE, 0);
        setd(1, 2'b00, 6'b001000, 4'd1, 16'h0000, 0, 0, 0);
        chk("stm0 next BusyD", bus.BusyD, 0);
        tick;
        chk("stm0 next RegWE", bus.RegWE, 1);

        // STM 0x00F0 with a stall on the second beat
        setd(1, 2'b10, 6'b000000, 4'd0, 16'h00F0, 0, 0, 0);
        chk("stmF b1 SeqRegD", bus.SeqRegD, 4);
        chk("stmF b1 RegSrcD", bus.RegSrcD, 2'b10);
        tick;
        chk("stmF b1 MemWE", bus.MemWE, 1);
        chk("stmF b1 SeqRegE", bus.SeqRegE, 4);
        setd(1, 2'b10, 6'b000000, 4'd0, 16'h00F0, 1, 0, 0);
        tick;
        chk("stmF stall MemWE", bus.MemWE, 0);
        setd(1, 2'b10, 6'b000000, 4'd0, 16'h00F0, 0, 0, 0);
        chk("stmF b2 SeqRegD", bus.SeqRegD, 5);
        tick;
        chk("stmF b2 MemWE", bus.MemWE, 1);
        chk("stmF b2 SeqRegE", bus.SeqRegE, 5);
        chk("stmF b2 SeqOffE", bus.SeqOffE, 1);
        tick;
        chk("stmF b3 SeqRegE", bus.SeqRegE, 6);
        chk("stmF b3 SeqOffE", bus.SeqOffE, 2);
        chk("stmF b4 BusyD", bus.BusyD, 0);
        tick;
        chk("stmF b4 SeqRegE", bus.SeqRegE, 7);
        chk("stmF b4 SeqOffE", bus.SeqOffE, 3);

        // FlushD after beat 1 of STM 0x0F00
        setd(1, 2'b10, 6'b000000, 4'd0, 16'h0F00, 0, 0, 0);
        tick;
        chk("fl b1 SeqRegE", bus.SeqRegE, 8);
        chk("fl b1 MemWE", bus.MemWE, 1);
        setd(1, 2'b10, 6'b000000, 4'd0, 16'h0F00, 0, 1, 0);
        chk("fl BusyD during flush", bus.BusyD, 0);
        tick;
        chk("fl bubble MemWE", bus.MemWE, 0);
        setd(0, 2'b10, 6'b000000, 4'd0, 16'h0F00, 0, 0, 0);
        chk("fl after BusyD", bus.BusyD, 0);
        tick;
        chk("fl after MemWE", bus.MemWE, 0);
        chk("fl after SeqRegE", bus.SeqRegE, 0);

        // Reset mid-XFER of LDM 0x8003
        setd(1, 2'b10, 6'b000001, 4'd0, 16'h8003, 0, 0, 0);
        tick;
        chk("rx b1 RegWE", bus.RegWE, 1);
        reset = 1'b1;
        tick;
        chk("rx RegWE", bus.RegWE, 0);
        chk("rx SeqOffE", bus.SeqOffE, 0);
        reset = 1'b0;
        setd(0, 2'b10, 6'b000001, 4'd0, 16'h8003, 0, 0, 0);
        chk("rx BusyD", bus.BusyD, 0);
        tick;
        chk("rx idle RegWE", bus.RegWE, 0);

        // REGS=8 build: LDM 0x83 -> r0, r1, r7
        setd(1, 2'b10, 6'b000001, 4'd0, 16'h0083, 0, 0, 0);
        chk("r8 b1 BusyD", bus8.BusyD, 1);
        chk("r8 b1 SeqRegD", bus8.SeqRegD, 0);
        tick;
        chk("r8 b1 SeqRegE", bus8.SeqRegE, 0);
        chk("r8 b1 SeqOffE", bus8.SeqOffE, 0);
        chk("r8 b2 BusyD", bus8.BusyD, 1);
        tick;
        chk("r8 b2 SeqRegE", bus8.SeqRegE, 1);
        chk("r8 b2 SeqOffE", bus8.SeqOffE, 1);
        chk("r8 b3 BusyD", bus8.BusyD, 0);
        chk("r8 b3 SeqRegD", bus8.SeqRegD, 7);
        tick;
        chk("r8 b3 SeqRegE", bus8.SeqRegE, 7);
        chk("r8 b3 SeqOffE", bus8.SeqOffE, 2);
        chk("r8 b3 PCSE", bus8.PCSE, 0);
        chk("r8 b3 RegWE", bus8.RegWE, 1);
        setd(0, 2'b00, 6'b000000, 4'd0, 16'h0000, 0, 0, 0);
        tick;
        chk("r8 idle RegWE", bus8.RegWE, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
